// File: rtl/mem_ctrl_pkg.sv
// Shared types and helpers for the byte-serial memory controller.
// Byte-count encodings, FSM state encoding and the latched transfer descriptor.
package mem_ctrl_pkg;

  localparam int unsigned MC_ADDR_W = 32;
  localparam int unsigned MC_DATA_W = 32;
  localparam int unsigned CNT_W     = 3;

  localparam logic [2:0] BYTES1 = 3'b001;
  localparam logic [2:0] BYTES2 = 3'b010;
  localparam logic [2:0] BYTES4 = 3'b100;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RD_MEM = 3'd1,
    ST_WR_MEM = 3'd2,
    ST_RD_IF  = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

  typedef struct packed {
    logic [MC_ADDR_W-1:0] base;
    logic [CNT_W-1:0]     n;
    logic [MC_DATA_W-1:0] wdata;
  } xfer_t;

  // Unknown encodings fall back to a full word
  function automatic logic [CNT_W-1:0] decode_nbytes(input logic [2:0] enc);
    case (enc)
      BYTES1:  return CNT_W'(1);
      BYTES2:  return CNT_W'(2);
      BYTES4:  return CNT_W'(4);
      default: return CNT_W'(4);
    endcase
  endfunction

  function automatic logic [MC_DATA_W-1:0] put_byte(input logic [MC_DATA_W-1:0] w,
                                                    input logic [1:0] idx,
                                                    input logic [7:0] b);
    logic [MC_DATA_W-1:0] r;
    r = w;
    r[{idx, 3'b000} +: 8] = b;
    return r;
  endfunction

  function automatic logic [7:0] get_byte(input logic [MC_DATA_W-1:0] w, input logic [1:0] idx);
    return w[{idx, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Arbitrates MEM loads/stores against IF fetches and sequences 1/2/4-byte
// transfers over an 8-bit RAM port, one byte per cycle.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = MC_ADDR_W,
  parameter int unsigned DATA_W = MC_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic              load_or_not,
  input  logic              store_or_not,
  input  logic [2:0]        num_of_bytes,
  input  logic [DATA_W-1:0] store_data,
  output logic [DATA_W-1:0] load_data,
  output logic              mem_enable,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic [DATA_W-1:0] inst,
  output logic              inst_valid,
  input  logic [7:0]        ram_din,
  output logic [7:0]        ram_dout,
  output logic [ADDR_W-1:0] ram_a,
  output logic              ram_wr
);

  state_e            state, state_d;
  xfer_t             xfer, xfer_d;
  logic [CNT_W-1:0]  cnt, cnt_d;
  logic              op_if, op_if_d;
  logic [DATA_W-1:0] asm_q, asm_word;
  logic              capture, last_rd;
  logic [ADDR_W-1:0] ram_a_d;
  logic [7:0]        ram_dout_d;
  logic              wr_q, wr_d, men_q, men_d, iv_q, iv_d;

  // State register; rdy=0 freezes everything
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)     state <= ST_IDLE;
    else if (rdy) state <= state_d;
  end

  // Next state, grant and byte counter
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    xfer_d  = xfer;
    op_if_d = op_if;
    case (state)
      ST_IDLE: begin
        cnt_d = '0;
        if (store_or_not) begin
          state_d = ST_WR_MEM;
          op_if_d = 1'b0;
          xfer_d  = '{base: mem_addr_i, n: decode_nbytes(num_of_bytes), wdata: store_data};
        end else if (load_or_not) begin
          state_d = ST_RD_MEM;
          op_if_d = 1'b0;
          xfer_d  = '{base: mem_addr_i, n: decode_nbytes(num_of_bytes), wdata: store_data};
        end else if (if_req && !if_flush) begin
          state_d = ST_RD_IF;
          op_if_d = 1'b1;
          xfer_d  = '{base: if_addr, n: CNT_W'(4), wdata: '0};
        end
      end
      ST_RD_MEM, ST_RD_IF: begin
        if (state == ST_RD_IF && if_flush) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt == xfer.n) begin
          state_d = ST_DONE;
        end else begin
          cnt_d = CNT_W'(cnt + CNT_W'(1));
        end
      end
      ST_WR_MEM: begin
        if (cnt == CNT_W'(xfer.n - CNT_W'(1))) state_d = ST_DONE;
        else                                    cnt_d   = CNT_W'(cnt + CNT_W'(1));
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Next values of the registered RAM-side and completion outputs
  always_comb begin
    ram_a_d    = ram_a;
    ram_dout_d = ram_dout;
    wr_d       = 1'b0;
    men_d      = 1'b0;
    iv_d       = 1'b0;
    case (state_d)
      ST_RD_MEM, ST_RD_IF: begin
        if (cnt_d < xfer_d.n) ram_a_d = ADDR_W'(xfer_d.base + MC_ADDR_W'(cnt_d));
      end
      ST_WR_MEM: begin
        ram_a_d    = ADDR_W'(xfer_d.base + MC_ADDR_W'(cnt_d));
        ram_dout_d = get_byte(xfer_d.wdata, cnt_d[1:0]);
        wr_d       = 1'b1;
      end
      ST_DONE: begin
        men_d = !op_if_d;
        iv_d  = op_if_d;
      end
      default: ;
    endcase
  end

  // Byte k arrives one cycle after its address, i.e. while cnt == k+1
  assign capture  = (state == ST_RD_MEM || state == ST_RD_IF) && (cnt != '0);
  assign last_rd  = capture && (cnt == xfer.n);
  assign asm_word = put_byte(asm_q, 2'(cnt - CNT_W'(1)), ram_din);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt       <= '0;
      xfer      <= '0;
      op_if     <= 1'b0;
      asm_q     <= '0;
      load_data <= '0;
      inst      <= '0;
      ram_a     <= '0;
      ram_dout  <= '0;
      wr_q      <= 1'b0;
      men_q     <= 1'b0;
      iv_q      <= 1'b0;
    end else if (rdy) begin
      cnt      <= cnt_d;
      xfer     <= xfer_d;
      op_if    <= op_if_d;
      ram_a    <= ram_a_d;
      ram_dout <= ram_dout_d;
      wr_q     <= wr_d;
      men_q    <= men_d;
      iv_q     <= iv_d;
      if (state == ST_IDLE) asm_q <= '0;
      else if (capture)     asm_q <= asm_word;
      if (last_rd && state == ST_RD_MEM)             load_data <= asm_word;
      if (last_rd && state == ST_RD_IF && !if_flush) inst      <= asm_word;
    end
  end

  // A stalled cycle must neither write RAM nor signal completion
  assign ram_wr     = wr_q  & rdy;
  assign mem_enable = men_q & rdy;
  assign inst_valid = iv_q  & rdy;

endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: RAM model plus a transaction-level reference memory;
// every cycle of each transfer is checked against the expected timeline.
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst, rdy;
  logic [31:0] mem_addr_i, store_data, load_data, if_addr, inst, ram_a;
  logic        load_or_not, store_or_not, mem_enable, if_req, if_flush, inst_valid, ram_wr;
  logic [2:0]  num_of_bytes;
  logic [7:0]  ram_din = 8'h00;
  logic [7:0]  ram_dout;

  int total = 0;
  int bad   = 0;
  int wr_count = 0;
  logic [7:0]  ram_mem [logic [31:0]];
  logic [7:0]  ref_mem [logic [31:0]];
  logic [31:0] a_hold  = '0;
  logic        rd_hold = 1'b0;
  logic [31:0] last_inst;

  mem_ctrl dut (
    .clk(clk), .rst(rst), .rdy(rdy), .mem_addr_i(mem_addr_i), .load_or_not(load_or_not),
    .store_or_not(store_or_not), .num_of_bytes(num_of_bytes), .store_data(store_data),
    .load_data(load_data), .mem_enable(mem_enable), .if_req(if_req), .if_addr(if_addr),
    .if_flush(if_flush), .inst(inst), .inst_valid(inst_valid), .ram_din(ram_din),
    .ram_dout(ram_dout), .ram_a(ram_a), .ram_wr(ram_wr)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] dflt(input logic [31:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h3C;
  endfunction
  function automatic logic [7:0] ram_rd(input logic [31:0] a);
    return ram_mem.exists(a) ? ram_mem[a] : dflt(a);
  endfunction
  function automatic logic [7:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
  endfunction

  // Synchronous RAM halted by rdy: address sampled mid-cycle, data returned next cycle
  always @(negedge clk) begin
    a_hold  = ram_a;
    rd_hold = rdy;
    if (ram_wr) begin
      ram_mem[ram_a] = ram_dout;
      wr_count++;
    end
  end
  always @(posedge clk) if (rd_hold) ram_din <= ram_rd(a_hold);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_load_data"}, load_data, 32'h0);
    check({tag, "_inst"}, inst, 32'h0);
    check({tag, "_mem_enable"}, 32'(mem_enable), 32'h0);
    check({tag, "_inst_valid"}, 32'(inst_valid), 32'h0);
    check({tag, "_ram_a"}, ram_a, 32'h0);
    check({tag, "_ram_dout"}, 32'(ram_dout), 32'h0);
    check({tag, "_ram_wr"}, 32'(ram_wr), 32'h0);
  endtask

  // kind: 0 load, 1 store, 2 fetch. Cycle 0 is the grant cycle (controller idle, request up).
  task automatic do_op(input int kind, input logic [31:0] addr, input logic [2:0] enc,
                       input logic [31:0] wd, input bit step, input int stall_at,
                       input int stall_len, input bit rnd, output int cyc);
    int n, lat, e, c, k, wr0;
    bit done, prev_rdy, act;
    logic [31:0] exp_word;
    n   = (kind == 2) ? 4 : (enc == 3'b001) ? 1 : (enc == 3'b010) ? 2 : 4;
    lat = (kind == 0) ? n + 2 : (kind == 1) ? n + 1 : 6;
    exp_word = '0;
    for (int i = 0; i < n; i++) exp_word[8*i +: 8] = ref_rd(addr + 32'(i));
    if (step) begin @(posedge clk); #1; end
    rdy = 1'b1;
    case (kind)
      0: begin mem_addr_i = addr; num_of_bytes = enc; load_or_not = 1'b1; end
      1: begin mem_addr_i = addr; num_of_bytes = enc; store_data = wd; store_or_not = 1'b1; end
      default: begin if_addr = addr; if_req = 1'b1; end
    endcase
    wr0 = wr_count; e = 0; c = 0; done = 1'b0;
    while (!done && c < 200) begin
      prev_rdy = rdy;
      @(posedge clk); #1;
      c++;
      if (prev_rdy) e++;
      if (c >= stall_at && c < stall_at + stall_len) rdy = 1'b0;
      else if (rnd && $urandom_range(0, 4) == 0)     rdy = 1'b0;
      else                                           rdy = 1'b1;
      if (rnd) begin
        mem_addr_i = $urandom; num_of_bytes = 3'($urandom_range(0, 7)); store_data = $urandom;
        if (kind != 2) if_flush = 1'($urandom_range(0, 1));
      end
      #1;
      k = e - 1;
      act = (e >= 1 && k < n);
      if (act) check("ram_a", ram_a, addr + 32'(k));
      if (act && kind == 1) check("ram_dout", 32'(ram_dout), 32'(wd[8*k +: 8]));
      check("ram_wr", 32'(ram_wr), 32'(kind == 1 && act && rdy));
      check("mem_enable", 32'(mem_enable), 32'(kind != 2 && e == lat && rdy));
      check("inst_valid", 32'(inst_valid), 32'(kind == 2 && e == lat && rdy));
      if (e == lat && rdy) done = 1'b1;
    end
    cyc = c;
    if (!done) check("completion_timeout", 32'h0, 32'h1);
    load_or_not = 1'b0; store_or_not = 1'b0; if_flush = 1'b0; rdy = 1'b1;
    if (kind == 2) if_req = 1'b0;
    if (kind == 0) check("load_data", load_data, exp_word);
    if (kind == 2) begin check("inst", inst, exp_word); last_inst = exp_word; end
    if (kind == 1) begin
      check("write_count", 32'(wr_count - wr0), 32'(n));
      for (int i = 0; i < n; i++) begin
        ref_mem[addr + 32'(i)] = wd[8*i +: 8];
        check("ram_content", 32'(ram_rd(addr + 32'(i))), 32'(wd[8*i +: 8]));
      end
    end
  endtask

  initial begin
    int cyc;
    logic [31:0] ra;
    rst = 1'b0; rdy = 1'b1; mem_addr_i = '0; load_or_not = 1'b0; store_or_not = 1'b0;
    num_of_bytes = 3'b100; store_data = '0; if_req = 1'b0; if_addr = '0; if_flush = 1'b0;
    last_inst = '0;
    #12;
    check_reset_outputs("reset");
    @(posedge clk); #1; rst = 1'b1;

    // LW at 0x100
    for (int i = 0; i < 4; i++) begin
      ram_mem[32'h100 + 32'(i)] = 8'(8'h11 * (i + 1));
      ref_mem[32'h100 + 32'(i)] = 8'(8'h11 * (i + 1));
    end
    do_op(0, 32'h100, 3'b100, 32'h0, 1'b1, 0, 0, 1'b0, cyc);
    check("lw_value", load_data, 32'h44332211);
    check("lw_latency", 32'(cyc), 32'd6);

    // SB at 0x2
    do_op(1, 32'h2, 3'b001, 32'hABCD12EF, 1'b1, 0, 0, 1'b0, cyc);
    check("sb_latency", 32'(cyc), 32'd2);
    check("sb_byte", 32'(ram_rd(32'h2)), 32'hEF);
    check("sb_neighbour", 32'(ram_rd(32'h3)), 32'(dflt(32'h3)));

    // Load and fetch together: load first, fetch granted right after DONE
    if_addr = 32'h100; if_req = 1'b1;
    do_op(0, 32'h101, 3'b010, 32'h0, 1'b1, 0, 0, 1'b0, cyc);
    check("arb_load_value", load_data, 32'h00003322);
    do_op(2, 32'h100, 3'b000, 32'h0, 1'b1, 0, 0, 1'b0, cyc);
    check("arb_inst_value", inst, 32'h44332211);

    // Flush a fetch at cnt=2, then fetch a new address
    @(posedge clk); #1; if_addr = 32'h400; if_req = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      @(posedge clk); #1;
      check("flush_ram_a", ram_a, 32'h400 + 32'(c - 1));
      check("flush_iv", 32'(inst_valid), 32'h0);
    end
    if_flush = 1'b1;
    @(posedge clk); #1;
    check("flush_no_iv", 32'(inst_valid), 32'h0);
    check("flush_inst_hold", inst, last_inst);
    if_flush = 1'b0;
    do_op(2, 32'h500, 3'b000, 32'h0, 1'b0, 0, 0, 1'b0, cyc);
    check("refetch_latency", 32'(cyc), 32'd6);

    // SW with a 3-cycle stall after the first byte
    do_op(1, 32'h300, 3'b100, 32'hDEADBEEF, 1'b1, 2, 3, 1'b0, cyc);
    check("sw_stall_latency", 32'(cyc), 32'd8);

    // Reset in the middle of an LH
    @(posedge clk); #1; mem_addr_i = 32'h200; num_of_bytes = 3'b010; load_or_not = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0; load_or_not = 1'b0;
    #1;
    check_reset_outputs("midreset");
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      check("midreset_no_pulse", 32'(mem_enable), 32'h0);
    end
    rst = 1'b1;
    do_op(0, 32'h200, 3'b010, 32'h0, 1'b1, 0, 0, 1'b0, cyc);
    check("post_reset_lh_latency", 32'(cyc), 32'd4);

    // Random traffic with stalls, wrapping addresses and odd encodings
    for (int t = 0; t < 40; t++) begin
      ra = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFC + 32'($urandom_range(0, 3))
                                       : 32'($urandom_range(0, 63));
      do_op($urandom_range(0, 2), ra, 3'($urandom_range(0, 7)), $urandom, 1'b1, 0, 0, 1'b1, cyc);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
